out_trace_fifo: RTL
===================

Name: out_trace_fifo

Overview:
- Captures writes to the data path's output port (DATA_OUT/LED bus) into a parametrised FIFO.
- Each captured entry optionally carries a timestamp.
- The CPU core drives the capture side; a debug/UART/bench consumer drains the read side via valid/ready.
- Generalises the fixed 8-bit output port to any width and depth, adds change-only filtering, buffering and overflow accounting.

Parameters:
DATA_W, 8, width of captured output word.
DEPTH, 16, FIFO entries; power of 2, >= 2.
TS_W, 16, timestamp counter width (used only with TRACE_TS_EN).
CHANGE_ONLY, 1, 1 = capture only when the written value differs from the last written value; 0 = capture every write.
DROP_W, 8, width of the saturating dropped-event counter.

Ports:
clk  in  1  system clock, all state on rising edge.
resetn  in  1  asynchronous active-low reset.
data_in  in  DATA_W  value being written to the output port.
data_we  in  1  output-port write strobe, one event per cycle high.
rd_ready  in  1  consumer accepts head entry.
rd_valid  out  1  FIFO non-empty; head entry valid.
rd_data  out  DATA_W  head entry data (show-ahead).
rd_ts  out  TS_W  head entry timestamp.
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
overflow  out  1  sticky: an event was dropped.
ovf_clr  in  1  clears overflow and drop_cnt.
drop_cnt  out  DROP_W  dropped events, saturates at all-ones.

Behaviour:
- Reset (resetn low, async) clears:
  - outputs: rd_valid=0, rd_data=0, rd_ts=0, count=0, overflow=0, drop_cnt=0;
  - internal: pointers=0, last_value=0, timestamp counter=0.
- Reset asserted mid-operation discards all entries immediately. Operation resumes on the first rising edge after deassertion.
- Timestamp counter:
  - free-running, +1 every cycle;
  - wraps modulo 2^TS_W.
- Event definition: data_we=1 and (CHANGE_ONLY=0 or data_in != last_value).
- last_value updates to data_in on every data_we=1 cycle, whether or not an event fires or the event is dropped.
- Push:
  - on an event, entry {data_in, timestamp at that cycle} is written at the write pointer;
  - pointers wrap modulo DEPTH.
- Pop: rd_valid=1 and rd_ready=1 advances the read pointer.
- rd_valid/rd_data/rd_ts are show-ahead from FIFO storage; rd_valid = (count != 0).
- Latency: an event in cycle N into an empty FIFO gives rd_valid=1 with its data in cycle N+1. There is no bypass in the same cycle.
- Occupancy:
  - count +1 on push only, -1 on pop only;
  - unchanged on simultaneous push+pop.
- Full (count=DEPTH):
  - event with pop in the same cycle: accepted, count stays DEPTH;
  - event without pop: dropped; overflow<=1; drop_cnt increments, saturating at 2^DROP_W-1.
- Empty: rd_ready ignored; no pointer movement; rd_data/rd_ts hold last storage read (don't-care to consumer).
- ovf_clr=1:
  - overflow and drop_cnt <= 0 next edge;
  - if a drop occurs in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- Ordering: entries are popped strictly in push order. No reordering or coalescing beyond CHANGE_ONLY filtering.

Optional Feature:
- Macro OUT_TRACE_TS_EN.
- Defined:
  - timestamp counter and per-entry TS_W storage are instantiated;
  - rd_ts carries the captured timestamp.
- Undefined:
  - no counter or timestamp storage is synthesised;
  - rd_ts is tied to 0;
  - all other behaviour is identical.

Test Plan:
- Reset, then data_we pulses with 8'h01, 8'h01, 8'h02 (CHANGE_ONLY=1) -> exactly 2 entries, 01 then 02. rd_valid rises the cycle after the first write. Timestamps equal the write cycles' counter values.
- CHANGE_ONLY=0, same stimulus -> 3 entries 01, 01, 02; count reaches 3 with rd_ready=0.
- DEPTH=16, rd_ready=0, 20 distinct writes -> count=16, entries 1..16 retained, overflow=1, drop_cnt=4. Then ovf_clr -> overflow=0, drop_cnt=0, count still 16.
- Full FIFO, rd_ready=1 and a new distinct write in the same cycle -> entry accepted, count stays 16, no overflow. Drain order is preserved across pointer wrap.
- Fill with 5 entries, assert resetn=0 asynchronously between clock edges -> rd_valid, count and overflow drop to 0 immediately, without waiting for a clock edge. The first write after release is captured with timestamp counted from 0.
- Build without OUT_TRACE_TS_EN -> rd_ts=0 for all entries; data and ordering identical to the timestamped build.

Source files
------------

// File: rtl/out_trace_fifo.sv
// Output-port trace FIFO: captures data path output writes (optionally change-only) with show-ahead read.
// Define OUT_TRACE_TS_EN to add a free-running timestamp captured alongside each entry.
module out_trace_fifo #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int TS_W        = 16,
  parameter int CHANGE_ONLY = 1,
  parameter int DROP_W      = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     data_we,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic [TS_W-1:0]          rd_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [DROP_W-1:0]        drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       cnt;
  logic [DATA_W-1:0] last_value;
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              ev, pop, push, drop;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  // A full FIFO still accepts an event when the head is popped in the same cycle
  always_comb begin
    ev   = data_we && ((CHANGE_ONLY == 0) || (data_in != last_value));
    pop  = (cnt != '0) && rd_ready;
    push = ev && ((cnt != FULL_CNT) || pop);
    drop = ev && (cnt == FULL_CNT) && !pop;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      last_value <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (data_we) last_value <= data_in;
      if (push)    wptr <= wptr + PTR_ONE;
      if (pop)     rptr <= rptr + PTR_ONE;
      if (push && !pop)      cnt <= cnt + CNT_ONE;
      else if (pop && !push) cnt <= cnt - CNT_ONE;
      // A drop in the same cycle as a clear restarts accounting at one
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= ovf_clr ? DROP_W'(1) : sat_inc(drop_cnt);
      end else if (ovf_clr) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] <= '0;
    end else if (push) begin
      mem_d[wptr] <= data_in;
    end
  end

  assign rd_valid = (cnt != '0);
  assign rd_data  = mem_d[rptr];
  assign count    = cnt;

`ifdef OUT_TRACE_TS_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] mem_t [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ts_cnt <= '0;
    else         ts_cnt <= ts_cnt + TS_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_t[i] <= '0;
    end else if (push) begin
      mem_t[wptr] <= ts_cnt;
    end
  end

  assign rd_ts = mem_t[rptr];
`else
  assign rd_ts = '0;
`endif

endmodule
